// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the EX/MEM pipeline stage
package pipe_pkg;

  // Bit positions inside the control bundle {memToReg, regWrite, memWrite, memRead}
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMREAD  = 0;

  // Default field widths of the stage
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_CTRL_WIDTH     = 4;

  // Encoding equals the number of held entries
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Payload layout at default widths; the stage packs fields in this order
  typedef struct packed {
    logic [DEF_CTRL_WIDTH-1:0]     ctrl;
    logic [DEF_DATA_WIDTH-1:0]     alu_result;
    logic [DEF_DATA_WIDTH-1:0]     mem_wdata;
    logic [DEF_REG_ADDR_WIDTH-1:0] reg_waddr;
  } ex_mem_payload_t;

  function automatic logic [1:0] occupancy_of(input skid_state_t s);
    return logic'(s == TWO) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - generic 2-entry elastic register with registered ready and flush
module skid_buffer
  import pipe_pkg::*;
#(
  parameter int             W          = 8,
  parameter logic [W-1:0]   FLUSH_MASK = '0   // bits cleared in both entries on flush
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occupancy_o
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_fire, out_fire;

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign in_ready_o  = in_ready_q;
  assign occupancy_o = occupancy_of(state_q);

  // Next-state and storage update; flush overrides every handshake event
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = in_valid_i & in_ready_q;
    out_fire = out_valid_o & out_ready_i;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q & ~FLUSH_MASK;
      skid_d  = skid_q & ~FLUSH_MASK;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Ready is precomputed so it never depends combinationally on out_ready_i
    in_ready_d = (state_d != TWO);
  end

  // State, storage and ready registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline stage with handshake, skid buffer and flush
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_WIDTH-1:0]     ctrl_in,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     mem_wdata_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_WIDTH-1:0]     ctrl_out,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [DATA_WIDTH-1:0]     mem_wdata_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_out,
  output logic [1:0]                occupancy
);

  localparam int PW = CTRL_WIDTH + 2 * DATA_WIDTH + REG_ADDR_WIDTH;
  // Only the control bundle is squashed on flush; data fields may keep stale values
  localparam logic [PW-1:0] CTRL_MASK = {{CTRL_WIDTH{1'b1}}, {(PW - CTRL_WIDTH){1'b0}}};

  logic [PW-1:0]         pay_in, pay_out;
  logic [CTRL_WIDTH-1:0] ctrl_held;

  assign pay_in = {ctrl_in, alu_result_in, mem_wdata_in, reg_waddr_in};

  skid_buffer #(
    .W          (PW),
    .FLUSH_MASK (CTRL_MASK)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pay_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pay_out),
    .occupancy_o (occupancy)
  );

  assign {ctrl_held, alu_result_out, mem_wdata_out, reg_waddr_out} = pay_out;

  // An empty stage must never assert regWrite/memWrite downstream
  always_comb begin
    ctrl_out = '0;
    if (out_valid) ctrl_out = ctrl_held;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage against a queue model
module tb_ex_mem_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [3:0]  ctrl_in, ctrl_out;
  logic [31:0] alu_result_in, mem_wdata_in, alu_result_out, mem_wdata_out;
  logic [4:0]  reg_waddr_in, reg_waddr_out;
  logic [1:0]  occupancy;

  int compared   = 0;
  int mismatched = 0;

  ex_mem_payload_t q[$];
  ex_mem_payload_t disp;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ctrl_in        (ctrl_in),
    .alu_result_in  (alu_result_in),
    .mem_wdata_in   (mem_wdata_in),
    .reg_waddr_in   (reg_waddr_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ctrl_out       (ctrl_out),
    .alu_result_out (alu_result_out),
    .mem_wdata_out  (mem_wdata_out),
    .reg_waddr_out  (reg_waddr_out),
    .occupancy      (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic       ev;
    logic [3:0] ec;
    ev = (q.size() > 0);
    ec = ev ? q[0].ctrl : 4'h0;
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("ctrl_out", 64'(ctrl_out), 64'(ec));
    chk("alu_result_out", 64'(alu_result_out), 64'(disp.alu_result));
    chk("mem_wdata_out", 64'(mem_wdata_out), 64'(disp.mem_wdata));
    chk("reg_waddr_out", 64'(reg_waddr_out), 64'(disp.reg_waddr));
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [3:0] c,
                       input logic rdy, input logic fl, input logic rst);
    in_valid      = v;
    alu_result_in = alu;
    mem_wdata_in  = ~alu ^ 32'h5A5A_0000;
    reg_waddr_in  = alu[4:0] ^ 5'h13;
    ctrl_in       = c;
    out_ready     = rdy;
    flush         = fl;
    reset         = rst;
  endtask

  // One clock: update the FIFO model from the inputs seen at the edge, then compare
  task automatic step();
    bit              in_fire, out_fire;
    ex_mem_payload_t p;
    @(posedge clk);
    in_fire  = in_valid && (q.size() < 2);
    out_fire = out_ready && (q.size() > 0);
    p = '{ctrl_in, alu_result_in, mem_wdata_in, reg_waddr_in};
    if (reset) begin
      q.delete();
      disp = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(p);
    end
    if (q.size() > 0) disp = q[0];
    #1;
    check_all();
  endtask

  initial begin
    disp = '0;
    // Reset held with an active input that must be ignored
    drive(1'b1, 32'hDEAD, 4'hF, 1'b0, 1'b0, 1'b1);
    step(); step(); step();
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    step();

    // Streaming at full throughput
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 4'h4, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    step();

    // Backpressure: A, B fill the stage, C waits, then drain in order
    drive(1'b1, 32'h10, 4'h1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h20, 4'h2, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h30, 4'h3, 1'b0, 1'b0, 1'b0); step(); step(); step();
    drive(1'b1, 32'h30, 4'h3, 1'b1, 1'b0, 1'b0); step(); step();
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0); step(); step();

    // Flush while full, with an input presented in the flush cycle
    drive(1'b1, 32'h10, 4'h6, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h20, 4'h6, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h30, 4'hE, 1'b0, 1'b1, 1'b0); step();
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0); step(); step();

    // Gating: regWrite entry consumed, nothing new arrives
    drive(1'b1, 32'h77, 4'b0100, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0); step(); step();

    // Reset while full, then a single entry streams through
    drive(1'b1, 32'hA1, 4'h2, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hA2, 4'h2, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hA3, 4'h2, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 32'h55, 4'h4, 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0); step(); step();

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom(), 4'($urandom()),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 79) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
